// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 3-digit seven-segment scanner.
// Scan states, active-low segment patterns ({g,f,e,d,c,b,a}) and
// one-cold anode codes.
package seg7_pkg;

    // Scan state encoding: one state per digit slot
    localparam logic [1:0] SCAN0 = 2'd0;   // units
    localparam logic [1:0] SCAN1 = 2'd1;   // tens
    localparam logic [1:0] SCAN2 = 2'd2;   // hundreds

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Anode codes, active-low one-cold; an[0] is the units digit
    localparam logic [2:0] AN_D0  = 3'b110;
    localparam logic [2:0] AN_D1  = 3'b101;
    localparam logic [2:0] AN_D2  = 3'b011;
    localparam logic [2:0] AN_OFF = 3'b111;

endpackage

// File: rtl/seg7_scan3_if.sv
// seg7_scan3_if: BCD load side and display pin side of the scanner.
// master = producer/observer (bench or upstream), slave = the scanner.
interface seg7_scan3_if;
    logic [3:0] value0;
    logic [3:0] value1;
    logic [3:0] value2;
    logic       load;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_start;

    modport master (
        output value0, value1, value2, load,
        input  seg, an, frame_start
    );

    modport slave (
        input  value0, value1, value2, load,
        output seg, an, frame_start
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not decimal digits and show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit pattern lookup
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan3.sv
// seg7_scan3: time-multiplexed driver for a 3-digit common-anode display.
// Each digit owns a slot of REFRESH_DIV cycles; the first GAP cycles of a
// slot keep every anode off to stop ghosting between digits. New digits
// are staged in a pending register and only committed at the frame wrap,
// so one frame never mixes old and new values.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg7_scan3
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 500
)(
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan3_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0][3:0] r_pend;
    logic [2:0][3:0] r_disp;
    logic            r_flag;
    logic [6:0]      r_seg;
    logic [2:0]      r_an;
    logic            r_fs;

    logic            w_slot_end;
    logic            w_wrap;
    logic            w_blank;
    logic [3:0]      w_digit;
    logic [2:0]      w_an_cur;
    logic [6:0]      w_seg;

    assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_wrap     = w_slot_end && (r_state == SCAN2);

    // Next scan state and the digit/anode belonging to the current slot
    always_comb begin
        w_next   = SCAN0;
        w_digit  = r_disp[0];
        w_an_cur = AN_D0;
        case (r_state)
            SCAN0: begin w_next = SCAN1; w_digit = r_disp[0]; w_an_cur = AN_D0; end
            SCAN1: begin w_next = SCAN2; w_digit = r_disp[1]; w_an_cur = AN_D1; end
            SCAN2: begin w_next = SCAN0; w_digit = r_disp[2]; w_an_cur = AN_D2; end
            default: begin w_next = SCAN0; w_digit = r_disp[0]; w_an_cur = AN_D0; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Hundreds blank when zero; tens blank only if hundreds is blank too
    assign w_blank = ((r_state == SCAN2) && (r_disp[2] == 4'd0)) ||
                     ((r_state == SCAN1) && (r_disp[2] == 4'd0) && (r_disp[1] == 4'd0));
`else
    assign w_blank = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Slot counter and scan state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN0;
            r_cnt   <= '0;
        end else if (w_slot_end) begin
            r_state <= w_next;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Pending/display staging; a load on the wrap cycle bypasses pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_disp <= '0;
            r_flag <= 1'b0;
        end else if (w_wrap) begin
            if (bus.load) begin
                r_disp <= {bus.value2, bus.value1, bus.value0};
                r_flag <= 1'b0;
            end else if (r_flag) begin
                r_disp <= r_pend;
                r_flag <= 1'b0;
            end
        end else if (bus.load) begin
            r_pend <= {bus.value2, bus.value1, bus.value0};
            r_flag <= 1'b1;
        end
    end

    // Registered pins: gap and blanked slots keep everything dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
            r_fs  <= 1'b0;
        end else begin
            r_fs <= (r_state == SCAN0) && (r_cnt == '0);
            if ((r_cnt < CW'(GAP)) || w_blank) begin
                r_seg <= SEG_BLANK;
                r_an  <= AN_OFF;
            end else begin
                r_seg <= w_seg;
                r_an  <= w_an_cur;
            end
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan3.sv
// tb_seg7_scan3: directed bench for seg7_scan3 with REFRESH_DIV=8, GAP=2.
// Honours LEADING_ZERO_BLANK_EN the same way the design build does.
module tb_seg7_scan3;

    localparam int DIV   = 8;
    localparam int GP    = 2;
    localparam int FRAME = 3 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   k     = 0;   // rising edges since last reset release

    seg7_scan3_if bus();

    seg7_scan3 #(.REFRESH_DIV(DIV), .GAP(GP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hand-written active-low patterns {g,f,e,d,c,b,a}
    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: pat = 7'b1000000;
            4'd1: pat = 7'b1111001;
            4'd2: pat = 7'b0100100;
            4'd3: pat = 7'b0110000;
            4'd4: pat = 7'b0011001;
            4'd5: pat = 7'b0010010;
            4'd6: pat = 7'b0000010;
            4'd7: pat = 7'b1111000;
            4'd8: pat = 7'b0000000;
            4'd9: pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    // Run nedges cycles expecting digits e0..e2 on screen; optionally
    // drive one or two consecutive loads starting at frame position ld_pos.
    task automatic check_frame(input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input int nedges,
                               input int ld_pos, input int ld_n,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [3:0] b0,
                               input logic [3:0] b1, input logic [3:0] b2,
                               input string name);
        for (int i = 0; i < nedges; i++) begin
            int         p;
            int         pos;
            int         slot;
            int         c;
            logic [3:0] d;
            logic       blank;
            logic [2:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_fs;
            p = k % FRAME;
            if (ld_n > 0 && p == ld_pos) begin
                bus.load = 1'b1; bus.value0 = a0; bus.value1 = a1; bus.value2 = a2;
            end else if (ld_n > 1 && p == ld_pos + 1) begin
                bus.load = 1'b1; bus.value0 = b0; bus.value1 = b1; bus.value2 = b2;
            end else begin
                bus.load = 1'b0;
            end
            step();
            bus.load = 1'b0;
            pos  = (k - 1) % FRAME;
            slot = pos / DIV;
            c    = pos % DIV;
            d    = (slot == 0) ? e0 : (slot == 1) ? e1 : e2;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (slot == 2 && e2 == 4'd0) blank = 1'b1;
            if (slot == 1 && e2 == 4'd0 && e1 == 4'd0) blank = 1'b1;
`endif
            exp_fs = (pos == 0);
            if (c < GP || blank) begin
                exp_an  = 3'b111;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
                exp_seg = pat(d);
            end
            tests++;
            if (bus.an !== exp_an) begin
                fails++;
                $display("FAIL %s an k=%0d got %b exp %b", name, k, bus.an, exp_an);
            end
            tests++;
            if (bus.seg !== exp_seg) begin
                fails++;
                $display("FAIL %s seg k=%0d got %b exp %b", name, k, bus.seg, exp_seg);
            end
            tests++;
            if (bus.frame_start !== exp_fs) begin
                fails++;
                $display("FAIL %s frame_start k=%0d got %b exp %b", name, k, bus.frame_start, exp_fs);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        tests++;
        if (bus.seg !== 7'h7F) begin
            fails++; $display("FAIL %s seg got %b exp %b", name, bus.seg, 7'h7F);
        end
        tests++;
        if (bus.an !== 3'b111) begin
            fails++; $display("FAIL %s an got %b exp %b", name, bus.an, 3'b111);
        end
        tests++;
        if (bus.frame_start !== 1'b0) begin
            fails++; $display("FAIL %s frame_start got %b exp 0", name, bus.frame_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_scan();
        check_frame(0, 0, 0, FRAME, -1, 0, 0, 0, 0, 0, 0, 0, "scan_f1");
        check_frame(0, 0, 0, FRAME, -1, 0, 0, 0, 0, 0, 0, 0, "scan_f2");
    endtask

    task automatic test_load_mid();
        check_frame(0, 0, 0, FRAME, 10, 1, 2, 5, 1, 0, 0, 0, "load_mid_cur");
    endtask

    task automatic test_back_to_back();
        check_frame(2, 5, 1, FRAME, 4, 2, 3, 3, 3, 7, 7, 7, "load_mid_next");
    endtask

    task automatic test_wrap_load();
        check_frame(7, 7, 7, FRAME, FRAME - 1, 1, 9, 0, 0, 0, 0, 0, "back_to_back");
        check_frame(9, 0, 0, FRAME, 3, 1, 4, 4'hC, 8, 0, 0, 0, "wrap_load");
    endtask

    task automatic test_dash();
        check_frame(4, 4'hC, 8, FRAME, -1, 0, 0, 0, 0, 0, 0, 0, "dash");
    endtask

    task automatic test_reset_mid();
        check_frame(4, 4'hC, 8, 18, 2, 1, 1, 2, 3, 0, 0, 0, "pre_reset");
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        k = 0;
        check_frame(0, 0, 0, FRAME, -1, 0, 0, 0, 0, 0, 0, 0, "post_reset_f1");
        check_frame(0, 0, 0, FRAME, -1, 0, 0, 0, 0, 0, 0, 0, "post_reset_f2");
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.value0 = 4'd0;
        bus.value1 = 4'd0;
        bus.value2 = 4'd0;
        test_reset();
        test_scan();
        test_load_mid();
        test_back_to_back();
        test_wrap_load();
        test_dash();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
